// File: rtl/csa_accum_ctrl_if.sv
// Stream interface for csa_accum_ctrl.
// Groups the burst control, operand input stream and result output stream.
//   start/count       : burst request (count sampled with start while idle)
//   in_valid/in_ready : operand handshake, in_data carries the operand
//   out_valid/out_ready: result handshake, result/cout carry the resolved sum
//   busy              : controller is not idle
// master: the side that issues bursts and consumes results.
// slave : the accumulator controller.
interface csa_accum_ctrl_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic             cout;
  logic             busy;

  modport master (
    output start, count, in_valid, in_data, out_ready,
    input  in_ready, out_valid, result, cout, busy
  );

  modport slave (
    input  start, count, in_valid, in_data, out_ready,
    output in_ready, out_valid, result, cout, busy
  );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator sequencer with a carry-save core.
// A burst of `count` operands is compressed 3:2 into a redundant sum/carry pair,
// one operand per cycle, then resolved with a single carry-propagate add.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : csa_accum_ctrl_if.slave (start/count, operand stream, result stream, busy)
// Optional build macro CSA_RESOLVE_PIPE_EN splits the final add into a low-half
// and a high-half cycle (N must be even); results are identical in both builds.
module csa_accum_ctrl #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  csa_accum_ctrl_if.slave   bus
);

`ifdef CSA_RESOLVE_PIPE_EN
  localparam int unsigned H = N / 2;
  typedef enum logic [2:0] {StIdle, StAccum, StResLo, StResHi, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAccum, StResolve, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [N-1:0]     sum_q, sum_d;
  logic [N-1:0]     carry_q, carry_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [N-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic [N-2:0]     maj_lo;
`ifdef CSA_RESOLVE_PIPE_EN
  logic             lo_c_q, lo_c_d;
`endif

  // Majority bit N-1 would shift out of the carry word, so it is never formed.
  assign maj_lo = (sum_q[N-2:0] & carry_q[N-2:0]) |
                  (sum_q[N-2:0] & bus.in_data[N-2:0]) |
                  (carry_q[N-2:0] & bus.in_data[N-2:0]);

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    rem_d    = rem_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef CSA_RESOLVE_PIPE_EN
    lo_c_d   = lo_c_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            state_d = StAccum;
            rem_d   = bus.count;
            sum_d   = '0;
            carry_d = '0;
          end else begin
            // Empty burst: report a zero result without touching the operand stream.
            state_d  = StDone;
            result_d = '0;
            cout_d   = 1'b0;
          end
        end
      end
      StAccum: begin
        if (bus.in_valid) begin
          sum_d   = sum_q ^ carry_q ^ bus.in_data;
          carry_d = {maj_lo, 1'b0};
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
`ifdef CSA_RESOLVE_PIPE_EN
            state_d = StResLo;
`else
            state_d = StResolve;
`endif
          end
        end
      end
`ifdef CSA_RESOLVE_PIPE_EN
      StResLo: begin
        {lo_c_d, result_d[H-1:0]} = {1'b0, sum_q[H-1:0]} + {1'b0, carry_q[H-1:0]};
        state_d = StResHi;
      end
      StResHi: begin
        {cout_d, result_d[N-1:H]} = {1'b0, sum_q[N-1:H]} + {1'b0, carry_q[N-1:H]} +
                                    (H + 1)'(lo_c_q);
        state_d = StDone;
      end
`else
      StResolve: begin
        {cout_d, result_d} = {1'b0, sum_q} + {1'b0, carry_q};
        state_d = StDone;
      end
`endif
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sum_q    <= '0;
      carry_q  <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef CSA_RESOLVE_PIPE_EN
      lo_c_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef CSA_RESOLVE_PIPE_EN
      lo_c_q   <= lo_c_d;
`endif
    end
  end

  // Handshake outputs decode registered state only; no path from in_valid/out_ready.
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
module tb_csa_accum_ctrl;
  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 4;
`ifdef CSA_RESOLVE_PIPE_EN
  localparam int ResLat = 2;
`else
  localparam int ResLat = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [7:0] ops_q[$];

  csa_accum_ctrl_if #(.N(N), .CNT_W(CNT_W)) bus ();

  csa_accum_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: 3:2 compression expressed arithmetically. s+c+d = xor + 2*maj, and the
  // carry word is 2*maj truncated to N bits; cout is the carry of the final resolve add.
  function automatic void model(output logic [7:0] r, output logic c);
    logic [15:0] s, k, t, x, d;
    s = '0;
    k = '0;
    foreach (ops_q[i]) begin
      d = {8'h00, ops_q[i]};
      t = s + k + d;
      x = s ^ k ^ d;
      s = x;
      k = (t - x) & 16'h00ff;
    end
    t = s + k;
    r = t[7:0];
    c = t[8];
  endfunction

  // Runs one burst from ops_q; returns at the first negedge where out_valid is seen.
  task automatic do_burst(input int cnt, input int gap, output int lat,
                          output logic [7:0] res, output logic co,
                          output bit rdy_ok, output bit tmo);
    int acc, t;
    rdy_ok = 1'b1;
    tmo    = 1'b0;
    acc    = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.count = CNT_W'(cnt);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          bus.in_valid = 1'b0;
          if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = ops_q[i];
      if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
      if (i == 0) acc = cyc;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    t = 0;
    while (bus.out_valid !== 1'b1 && !tmo) begin
      @(negedge clk);
      t++;
      if (t > 200) tmo = 1'b1;
    end
    lat = cyc - acc;
    res = bus.result;
    co  = bus.cout;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.in_ready, bus.out_valid, bus.busy, bus.cout});
    end
    checks++;
    if (bus.result !== 8'd0) begin
      failures++;
      $display("FAIL reset_result got=%0d exp=0", bus.result);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [7:0] res; logic co; bit rok, tmo;
    ops_q = '{8'd3, 8'd5, 8'd7};
    do_burst(3, 0, lat, res, co, rok, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL basic_timeout got=timeout exp=out_valid"); end
    checks++;
    if (res !== 8'd15 || co !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got=%0d/%0b exp=15/0", res, co);
    end
    checks++;
    if (lat != 3 + ResLat) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, 3 + ResLat);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_handoff got=%b%b exp=00", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_cout();
    int lat; logic [7:0] res; logic co; bit rok, tmo;
    ops_q = '{8'd200, 8'd100};
    do_burst(2, 0, lat, res, co, rok, tmo);
    checks++;
    if (tmo || res !== 8'd44 || co !== 1'b1) begin
      failures++;
      $display("FAIL cout_result got=%0d/%0b tmo=%0b exp=44/1", res, co, tmo);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_count();
    @(negedge clk);
    bus.start = 1'b1;
    bus.count = '0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_state got=ov%b ir%b exp=ov1 ir0", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.result !== 8'd0 || bus.cout !== 1'b0) begin
      failures++;
      $display("FAIL zero_result got=%0d/%0b exp=0/0", bus.result, bus.cout);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_idle got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_gaps();
    int lat; logic [7:0] res, er; logic co, ec; bit rok, tmo;
    ops_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    model(er, ec);
    do_burst(2, 3, lat, res, co, rok, tmo);
    checks++;
    if (!rok) begin failures++; $display("FAIL gaps_in_ready got=dropped exp=held_high"); end
    checks++;
    if (tmo || res !== er || co !== ec) begin
      failures++;
      $display("FAIL gaps_result got=%0d/%0b tmo=%0b exp=%0d/%0b", res, co, tmo, er, ec);
    end
    checks++;
    if (lat != 2 + ResLat + 3) begin
      failures++;
      $display("FAIL gaps_latency got=%0d exp=%0d", lat, 2 + ResLat + 3);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int lat; logic [7:0] res, er; logic co, ec; bit rok, tmo;
    ops_q = '{8'd250, 8'd9};
    model(er, ec);
    bus.out_ready = 1'b0;
    do_burst(2, 0, lat, res, co, rok, tmo);
    checks++;
    if (tmo) begin failures++; $display("FAIL stall_timeout got=timeout exp=out_valid"); end
    for (int i = 0; i < 5; i++) begin
      bus.start = i[0];
      bus.count = 4'd5;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== er || bus.cout !== ec) begin
        failures++;
        $display("FAIL stall_hold cyc%0d got=ov%b %0d/%0b exp=ov1 %0d/%0b",
                 i, bus.out_valid, bus.result, bus.cout, er, ec);
      end
    end
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got=ov%b busy%b exp=00", bus.out_valid, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_start_ignored got=busy%b exp=0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] res; logic co; bit rok, tmo;
    @(negedge clk);
    bus.start = 1'b1;
    bus.count = 4'd3;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout} !== 4'b0000 ||
        bus.result !== 8'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b res=%0d exp=0000 res=0",
               {bus.in_ready, bus.out_valid, bus.busy, bus.cout}, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ops_q = '{8'd9};
    do_burst(1, 0, lat, res, co, rok, tmo);
    checks++;
    if (tmo || res !== 8'd9 || co !== 1'b0 || lat != 1 + ResLat) begin
      failures++;
      $display("FAIL midreset_rerun got=%0d/%0b lat=%0d tmo=%0b exp=9/0 lat=%0d",
               res, co, lat, tmo, 1 + ResLat);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, cnt, gap; logic [7:0] res, er; logic co, ec; bit rok, tmo;
    for (int b = 0; b < 8; b++) begin
      ops_q.delete();
      cnt = (b == 0) ? 15 : int'($urandom_range(1, 15));
      gap = (b == 0) ? 0 : int'($urandom_range(0, 2));
      for (int i = 0; i < cnt; i++) ops_q.push_back((b == 0) ? 8'hff : 8'($urandom));
      model(er, ec);
      do_burst(cnt, gap, lat, res, co, rok, tmo);
      checks++;
      if (tmo || res !== er || co !== ec) begin
        failures++;
        $display("FAIL random_result b%0d got=%0d/%0b tmo=%0b exp=%0d/%0b",
                 b, res, co, tmo, er, ec);
      end
      checks++;
      if (!rok || lat != cnt + ResLat + gap * (cnt - 1)) begin
        failures++;
        $display("FAIL random_timing b%0d got=lat%0d rdy%0b exp=lat%0d rdy1",
                 b, lat, rok, cnt + ResLat + gap * (cnt - 1));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.count     = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_cout();
    test_zero_count();
    test_gaps();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
